// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output.
// Framing errors (including break) and overruns are reported as one-cycle pulses.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [1:0]    sync_q, sync_d;
    logic          rxd_s;

    assign rxd_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        sync_d      = {sync_q[0], rxd};

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    // A high line at mid start bit means the low was only a glitch.
                    if (rxd_s) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxd_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        // Same-edge consumption frees the slot, so no overrun then.
                        if (valid_q && !ready) begin
                            overrun_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            sync_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            sync_q      <= sync_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: serial frames are driven bit by bit, the expected
// bytes and latencies are queued, and a monitor checks every accepted byte.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_fe   = 0;
    int exp_ov   = 0;
    int fe_seen  = 0;
    int ov_seen  = 0;
    logic prev_valid = 1'b0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_rx #(
        .CLOCK_FREQUENCY(1_600_000),
        .BAUD_RATE      (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // driver: sends the first nbits of an 8N1 frame (start, 8 data LSB first, stop)
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits,
                              input bit expect_byte);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        if (expect_byte) begin
            exp_q.push_back(b);
            start_q.push_back(cyc);
        end
        for (int i = 0; i < nbits; i++) begin
            rxd = fr[i];
            tick(CPB);
        end
    endtask

    task automatic idle_and_check(input string name);
        rxd = 1'b1;
        tick(3 * CPB);
        check_eq({name, "_pending"}, exp_q.size(), 0);
        check_eq({name, "_frame_err_cnt"}, fe_seen, exp_fe);
        check_eq({name, "_overrun_cnt"}, ov_seen, exp_ov);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && !prev_valid) begin
                if (start_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: data %0h with nothing expected", data);
                end else begin
                    int s;
                    int lat;
                    s   = start_q.pop_front();
                    lat = cyc - s;
                    checks++;
                    if (lat < 156 || lat > 158) begin
                        failures++;
                        $display("FAIL latency: got %0d cycles expected 156..158", lat);
                    end
                end
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_accept: data %0h", data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check_eq("data", data, e);
                end
            end
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
        end
        prev_valid <= valid;
    end

    initial begin
        rst   = 1'b1;
        rxd   = 1'b1;
        ready = 1'b1;
        tick(5);
        check_eq("reset_data", data, 8'h00);
        check_eq("reset_valid", valid, 0);
        check_eq("reset_frame_err", frame_err, 0);
        check_eq("reset_overrun", overrun, 0);
        rst = 1'b0;
        tick(20);

        // single byte
        send_frame(8'hA5, 1'b1, 10, 1'b1);
        idle_and_check("single");

        // back-to-back with no idle gap
        send_frame(8'h00, 1'b1, 10, 1'b1);
        send_frame(8'hFF, 1'b1, 10, 1'b1);
        send_frame(8'h55, 1'b1, 10, 1'b1);
        idle_and_check("b2b");

        // glitch shorter than half a bit
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(40);
        send_frame(8'h3C, 1'b1, 10, 1'b1);
        idle_and_check("glitch");

        // bad stop bit followed by a held-low line
        send_frame(8'h12, 1'b0, 10, 1'b0);
        exp_fe++;
        tick(40);
        rxd = 1'b1;
        tick(2 * CPB);
        send_frame(8'h34, 1'b1, 10, 1'b1);
        idle_and_check("break");

        // consumer stalled across two frames
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 10, 1'b1);
        send_frame(8'h22, 1'b1, 10, 1'b0);
        exp_ov++;
        tick(CPB);
        check_eq("stall_data", data, 8'h11);
        check_eq("stall_valid", valid, 1);
        ready = 1'b1;
        tick(2);
        check_eq("stall_valid_drop", valid, 0);
        idle_and_check("overrun");

        // reset in the middle of the data bits
        send_frame(8'h77, 1'b1, 4, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("midreset_data", data, 8'h00);
        check_eq("midreset_valid", valid, 0);
        check_eq("midreset_frame_err", frame_err, 0);
        check_eq("midreset_overrun", overrun, 0);
        tick(2 * CPB);
        send_frame(8'h88, 1'b1, 10, 1'b1);
        idle_and_check("midreset");

        // random frames, some with a bad stop bit, random gaps
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            bit bad;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send_frame(b, !bad, 10, !bad);
            if (bad) exp_fe++;
            rxd = 1'b1;
            if (bad) tick($urandom_range(CPB, 3 * CPB));
            else tick($urandom_range(0, 2 * CPB));
        end
        idle_and_check("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that feeds the echo-back path: it converts the asynchronous serial line on `rxd` into bytes and presents each byte on a valid/ready handshake. Frame format is fixed 8N1: one start bit, 8 data bits LSB first, no parity, one stop bit. The block detects framing errors (including break) and overruns, and reports each as a one-cycle pulse.

## Interface
- `CLOCK_FREQUENCY`, default 100_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
  - CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE, integer division; must be ≥ 4.
  - HALF_BIT = CLKS_PER_BIT / 2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rxd`  in  1  asynchronous serial input; idles high.
- `data`  out  8  received byte; stable while `valid` is high.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts the byte when `valid && ready` at a rising edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good byte completed while `valid` was still high; that new byte is dropped.

## Operation
- Input conditioning: `rxd` passes through a 2-FF synchronizer to give `rxd_s`. The synchronizer resets to 1.
- State machine:
  - IDLE: when `rxd_s == 0`, clear the cycle counter and go to START.
  - START: after HALF_BIT cycles, sample `rxd_s`.
    - If 1, the low was a glitch; go to IDLE.
    - If 0, clear the counter and bit index; go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample `rxd_s` into shift bit [index], LSB first.
    - After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxd_s`.
    - If 1 and `valid == 0`: load `data`, set `valid`, go to IDLE.
    - If 1 and `valid == 1`: pulse `overrun`, keep the old `data`, go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait until `rxd_s == 1`, then go to IDLE. This prevents a held-low line from being re-read as a stream of 0x00 frames.
- Handshake:
  - `valid` clears on the edge where `valid && ready`.
  - `ready` is ignored while `valid == 0`.
  - Consumption and a new byte completing on the same edge:
    - the new byte loads into `data`;
    - `valid` stays 1;
    - no overrun is reported.
- Arithmetic:
  - The cycle counter is wide enough for CLKS_PER_BIT − 1 and saturates at nothing; it is cleared on every sample.
  - The bit index is 3 bits.
  - The receiver runs at free-running baud with no resync between bits. Tolerance is ±(50%/10 bits) minus the rounding of CLKS_PER_BIT.
- Reset: `rst` high at any time, including mid-frame, returns the block to IDLE.
  - The shift register and `data` clear to 0x00.
  - `valid`, `frame_err` and `overrun` clear to 0.
  - The first frame is recognised only after `rxd_s` is seen low while in IDLE; a line already low at reset release starts a frame immediately.

## Timing
- Reset values: `data` = 0x00, `valid` = 0, `frame_err` = 0, `overrun` = 0, state IDLE, synchronizer = 2'b11.
- Synchronizer latency: 2 cycles from `rxd` to `rxd_s`.
- Start sample: HALF_BIT cycles after entering START, i.e. mid start bit.
- Data bit k sample: (k+1)·CLKS_PER_BIT cycles after the start sample, for k = 0..7.
- Stop sample: 9·CLKS_PER_BIT cycles after the start sample.
- `valid`, `frame_err` and `overrun` change on the edge after the stop sample.
- End-to-end: the `valid` rise is 2 + 1 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles after the falling edge of the start bit (±1 cycle for `rxd` alignment).
- Back-to-back frames: after the stop sample the block is back in IDLE, with about HALF_BIT cycles of stop bit remaining. The next start edge is therefore caught even when frames have no idle gap.
- Throughput: one byte per 10 bit periods. The consumer must assert `ready` within ~10 bit periods of `valid` to avoid overrun.

## Test plan
All scenarios use CLOCK_FREQUENCY = 1_600_000 and BAUD_RATE = 100_000, so CLKS_PER_BIT = 16 and HALF_BIT = 8; `ready` is held at 1 unless stated.
- Single byte 0xA5 framed 8N1 → `valid` pulses one cycle with `data` = 0xA5, 157 ± 1 cycles after the start edge; `frame_err` and `overrun` stay 0.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three valid transfers in order, 160 cycles apart; no errors.
- Glitch: `rxd` low for 4 cycles, then high → no `valid`, block returns to IDLE; a following 0x3C is received correctly.
- Stop bit forced 0 with data 0x12, then line held low for 40 cycles before release → one `frame_err` pulse; no `valid`; no further frames until the line rises; a following 0x34 is received.
- `ready` = 0 while sending 0x11 then 0x22 → `data` = 0x11 with `valid` held; one `overrun` pulse at the end of the 0x22 frame. Raising `ready` afterwards consumes 0x11 and `valid` drops.
- `rst` asserted for 1 cycle in the middle of DATA of frame 0x77 → all outputs return to reset values; the partial frame is discarded; a following 0x88 is received with `data` = 0x88.
